imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader for the 32-bit word-organised instruction memory.
- Accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words and issues one write per word into consecutive word slots starting at a base byte address.
- Holds the core in reset (cpu_hold_out) until a load completes successfully.
- Sits between the external boot/UART byte source and the instruction memory write port.

Parameters:
- ADDR_WIDTH_POW, 6, log2 of address width
- ADDR_WIDTH, 1 << ADDR_WIDTH_POW (64), byte address width
- MEM_DEPTH_POW, 10, log2 of instruction memory depth in words
- MEM_DEPTH, 1 << MEM_DEPTH_POW (1024), words in instruction memory
- WORD_SIZE_POW, 2, log2 of bytes per word (fixed 4-byte words)

Ports:
- clk_in  input  1  clock, all state on rising edge
- rst_n_in  input  1  asynchronous active-low reset
- start_in  input  1  begin a load; sampled only in IDLE/DONE/ERR
- base_addr_in  input  ADDR_WIDTH  byte address of first word; captured on accepted start
- len_words_in  input  MEM_DEPTH_POW+1  number of words to load; captured on accepted start
- abort_in  input  1  cancel an in-progress load
- byte_valid_in  input  1  byte stream valid
- byte_data_in  input  8  byte stream data
- byte_ready_out  output  1  loader can accept a byte this cycle
- wr_en_out  output  1  instruction memory write strobe (one cycle per word)
- wr_addr_out  output  ADDR_WIDTH  byte address of word being written (word-aligned)
- wr_data_out  output  32  assembled word
- busy_out  output  1  load in progress (RECV or WRITE)
- done_out  output  1  sticky, last load completed
- error_out  output  1  sticky, last start rejected or load aborted
- cpu_hold_out  output  1  core held in reset

Behaviour:
- Reset (async, rst_n_in low): state IDLE. byte_ready_out, wr_en_out, busy_out, done_out and error_out are 0. wr_addr_out and wr_data_out are 0. cpu_hold_out is 1. Word index, byte count and shift register are 0.
- States: IDLE, RECV, WRITE, DONE, ERR.
- Accepted start (state IDLE, DONE or ERR with start_in=1):
  - Clear done_out and error_out; set cpu_hold_out=1.
  - If base_addr_in[1:0]!=0, or (base_addr_in>>2) + len_words_in > MEM_DEPTH (computed at ADDR_WIDTH+1 bits, no wrap): go to ERR.
  - Else if len_words_in==0: go to DONE.
  - Else capture base and len, reset index and byte count, go to RECV.
- RECV:
  - byte_ready_out=1.
  - On valid&&ready, the byte is placed at bits [8*cnt+7:8*cnt], so the first byte is the LSB.
  - cnt increments; when the 4th byte is accepted, go to WRITE.
- WRITE (exactly 1 cycle):
  - wr_en_out=1, wr_addr_out = base + (index << 2), wr_data_out = assembled word, byte_ready_out=0.
  - Next cycle: index+1. If index+1==len, go to DONE; else go to RECV.
- Throughput: minimum 5 cycles per word (4 byte beats + 1 write). No bytes are dropped while ready is low; the source must hold them.
- DONE: done_out=1 and cpu_hold_out=0, both held until the next accepted start. byte_ready_out=0.
- ERR: error_out=1 and cpu_hold_out=1, both held until the next accepted start.
- abort_in in RECV or WRITE goes to ERR next cycle. A WRITE-cycle write still completes that cycle. A partial word is discarded. abort_in in any other state is ignored.
- start_in in RECV/WRITE is ignored. Simultaneous abort_in and start_in: abort wins.
- Mid-load reset: everything returns to reset values immediately. Memory contents already written are unspecified-valid; no rollback.
- wr_en_out is registered (asserted only in the WRITE state) and is never high in two consecutive cycles.
- wr_addr_out and wr_data_out hold their last values outside WRITE.

Decomposition:
- Package imem_pkg: state enum imem_ld_state_t {IDLE, RECV, WRITE, DONE, ERR}; constant WORD_BYTES=4.
- One natural sub-module: byte_to_word_packer (byte count, shift register, word_valid pulse).
- The FSM, bounds check and address generation stay in imem_loader.

Test Plan:
- Reset then idle: rst_n low→high → cpu_hold_out=1, done_out=0, byte_ready_out=0, no wr_en_out pulses for 20 cycles.
- Basic load: base=0x100, len=2, bytes 13 00 00 00 93 00 10 00 → writes (0x100, 0x00000013), (0x104, 0x00100093); done_out=1, cpu_hold_out=0.
- Backpressure/gaps: same load with byte_valid_in deasserted for random 0–5 cycles between bytes → identical writes. byte_ready_out=0 in every WRITE cycle.
- Bounds and alignment: base=0x2, len=1 → error_out=1, no writes. base=0xFFC, len=2 → ERR. base=0xFFC, len=1 → write at 0xFFC, DONE. len=0 → DONE with no writes.
- Abort: abort_in after 2 bytes of word 1 (len=3, word 0 written) → ERR, exactly 1 write, cpu_hold_out=1. A new start then loads correctly.
- Async reset mid-load: rst_n_in low during RECV → outputs take reset values immediately. Restart load succeeds; start_in during RECV is ignored.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_pkg;

  localparam int WORD_BYTES    = 4;
  localparam int WORD_SIZE_POW = 2;
  localparam int CNT_W         = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } imem_ld_state_t;

endpackage

// File: rtl/imem_loader_packer.sv
// Assembles a little-endian byte stream into 32-bit words; first byte lands in the LSB.
module byte_to_word_packer
  import imem_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        clear_i,
  input  logic        fire_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      shift_q, shift_d;

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    word_valid_o = 1'b0;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (fire_i) begin
      shift_d[{cnt_q, 3'b000} +: 8] = byte_i;
      cnt_d        = cnt_q + CNT_W'(1);
      word_valid_o = (cnt_q == CNT_W'(WORD_BYTES - 1));
    end
  end

  // word_o includes the byte being accepted this cycle so the loader can latch a full word.
  assign word_o = shift_d;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into consecutive instruction memory words and holds the
// core in reset until a load completes.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH_POW = 6,
  parameter int ADDR_WIDTH     = 1 << ADDR_WIDTH_POW,
  parameter int MEM_DEPTH_POW  = 10,
  parameter int MEM_DEPTH      = 1 << MEM_DEPTH_POW
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    start_in,
  input  logic [ADDR_WIDTH-1:0]   base_addr_in,
  input  logic [MEM_DEPTH_POW:0]  len_words_in,
  input  logic                    abort_in,
  input  logic                    byte_valid_in,
  input  logic [7:0]              byte_data_in,
  output logic                    byte_ready_out,
  output logic                    wr_en_out,
  output logic [ADDR_WIDTH-1:0]   wr_addr_out,
  output logic [31:0]             wr_data_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    error_out,
  output logic                    cpu_hold_out
);

  imem_ld_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]             wr_data_q, wr_data_d;
  logic [MEM_DEPTH_POW:0]  len_q, len_d;
  logic [MEM_DEPTH_POW:0]  idx_q, idx_d;
  logic [MEM_DEPTH_POW:0]  idx_inc;
  logic [ADDR_WIDTH:0]     end_word;

  logic        start_ok;
  logic        abort_ok;
  logic        range_bad;
  logic        pk_fire;
  logic        pk_clear;
  logic        pk_word_valid;
  logic [31:0] pk_word;

  assign busy_out       = (state_q == RECV) || (state_q == WRITE);
  assign byte_ready_out = (state_q == RECV);
  assign wr_en_out      = (state_q == WRITE);
  assign done_out       = (state_q == DONE);
  assign error_out      = (state_q == ERR);
  assign cpu_hold_out   = (state_q != DONE);
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;

  assign start_ok = start_in && !busy_out;
  assign abort_ok = abort_in && busy_out;
  assign pk_fire  = byte_valid_in && byte_ready_out;
  assign pk_clear = start_ok || abort_ok;
  assign idx_inc  = idx_q + 1'b1;

  // One extra bit so a base near the top of the address space cannot wrap past the check.
  assign end_word  = (ADDR_WIDTH+1)'(base_addr_in >> WORD_SIZE_POW)
                   + (ADDR_WIDTH+1)'(len_words_in);
  assign range_bad = (base_addr_in[WORD_SIZE_POW-1:0] != '0)
                  || (end_word > (ADDR_WIDTH+1)'(MEM_DEPTH));

  byte_to_word_packer u_packer (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .clear_i      (pk_clear),
    .fire_i       (pk_fire),
    .byte_i       (byte_data_in),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start_ok) begin
          if (range_bad) begin
            state_d = ERR;
          end else if (len_words_in == '0) begin
            state_d = DONE;
          end else begin
            base_d  = base_addr_in;
            len_d   = len_words_in;
            idx_d   = '0;
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (abort_in) begin
          state_d = ERR;
        end else if (pk_word_valid) begin
          // Address and data are registered on entry to WRITE and held afterwards.
          wr_addr_d = base_q + (ADDR_WIDTH'(idx_q) << WORD_SIZE_POW);
          wr_data_d = pk_word;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (abort_in) begin
          state_d = ERR;
        end else begin
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? DONE : RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; logs every memory write and compares
// against hand-computed addresses and little-endian assembled words.
module tb_imem_loader;

  logic        clk;
  logic        rst_n_in;
  logic        start_in;
  logic [63:0] base_addr_in;
  logic [10:0] len_words_in;
  logic        abort_in;
  logic        byte_valid_in;
  logic [7:0]  byte_data_in;
  logic        byte_ready_out;
  logic        wr_en_out;
  logic [63:0] wr_addr_out;
  logic [31:0] wr_data_out;
  logic        busy_out;
  logic        done_out;
  logic        error_out;
  logic        cpu_hold_out;

  int passes = 0;
  int checks = 0;

  logic [63:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic        prev_wr = 1'b0;

  imem_loader dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n_in),
    .start_in       (start_in),
    .base_addr_in   (base_addr_in),
    .len_words_in   (len_words_in),
    .abort_in       (abort_in),
    .byte_valid_in  (byte_valid_in),
    .byte_data_in   (byte_data_in),
    .byte_ready_out (byte_ready_out),
    .wr_en_out      (wr_en_out),
    .wr_addr_out    (wr_addr_out),
    .wr_data_out    (wr_data_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .error_out      (error_out),
    .cpu_hold_out   (cpu_hold_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n_in) begin
      prev_wr = 1'b0;
    end else begin
      if (wr_en_out) begin
        check("wr_en_back_to_back", 64'(prev_wr), 64'd0);
        check("ready_low_in_write", 64'(byte_ready_out), 64'd0);
        wa_q.push_back(wr_addr_out);
        wd_q.push_back(wr_data_out);
      end
      prev_wr = wr_en_out;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic do_start(input logic [63:0] base, input logic [10:0] len);
    base_addr_in = base;
    len_words_in = len;
    start_in     = 1'b1;
    @(negedge clk);
    start_in     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid_in = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid_in = 1'b1;
    byte_data_in  = b;
    n = 0;
    while (!byte_ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("byte_accept", 64'(byte_ready_out), 64'd1);
    @(negedge clk);
    byte_valid_in = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    int g;
    for (int i = 0; i < 4; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      send_byte(w[8*i +: 8], g);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic expect_write(input string tag, input int idx,
                              input logic [63:0] a, input logic [31:0] d);
    if (idx < wa_q.size()) begin
      check({tag, "_addr"}, wa_q[idx], a);
      check({tag, "_data"}, 64'(wd_q[idx]), 64'(d));
    end else begin
      check({tag, "_missing"}, 64'(wa_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic expect_status(input string tag, input logic done, input logic err,
                               input logic hold, input logic busy);
    check({tag, "_done"}, 64'(done_out), 64'(done));
    check({tag, "_error"}, 64'(error_out), 64'(err));
    check({tag, "_hold"}, 64'(cpu_hold_out), 64'(hold));
    check({tag, "_busy"}, 64'(busy_out), 64'(busy));
  endtask

  initial begin
    rst_n_in      = 1'b0;
    start_in      = 1'b0;
    base_addr_in  = '0;
    len_words_in  = '0;
    abort_in      = 1'b0;
    byte_valid_in = 1'b0;
    byte_data_in  = '0;

    // Reset values while reset is asserted
    #3;
    expect_status("reset", 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_ready", 64'(byte_ready_out), 64'd0);
    check("reset_wr_en", 64'(wr_en_out), 64'd0);
    check("reset_wr_addr", wr_addr_out, 64'd0);
    check("reset_wr_data", 64'(wr_data_out), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n_in = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_no_writes", 64'(wa_q.size()), 64'd0);
    expect_status("idle", 1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_ready", 64'(byte_ready_out), 64'd0);

    // Basic two-word load
    clear_log();
    do_start(64'h100, 11'd2);
    check("basic_recv_ready", 64'(byte_ready_out), 64'd1);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    repeat (2) @(negedge clk);
    check("basic_count", 64'(wa_q.size()), 64'd2);
    expect_write("basic_w0", 0, 64'h100, 32'h0000_0013);
    expect_write("basic_w1", 1, 64'h104, 32'h0010_0093);
    expect_status("basic_end", 1'b1, 1'b0, 1'b0, 1'b0);
    check("basic_end_ready", 64'(byte_ready_out), 64'd0);

    // Same load with gaps between bytes
    clear_log();
    do_start(64'h100, 11'd2);
    check("gap_hold_on_start", 64'(cpu_hold_out), 64'd1);
    send_word(32'h0000_0013, 5);
    send_word(32'h0010_0093, 5);
    repeat (2) @(negedge clk);
    check("gap_count", 64'(wa_q.size()), 64'd2);
    expect_write("gap_w0", 0, 64'h100, 32'h0000_0013);
    expect_write("gap_w1", 1, 64'h104, 32'h0010_0093);
    expect_status("gap_end", 1'b1, 1'b0, 1'b0, 1'b0);

    // Misaligned base
    clear_log();
    do_start(64'h2, 11'd1);
    expect_status("misalign", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("misalign_no_writes", 64'(wa_q.size()), 64'd0);

    // Zero-length load completes immediately
    do_start(64'h300, 11'd0);
    expect_status("len0", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("len0_no_writes", 64'(wa_q.size()), 64'd0);

    // One word past the end of memory
    do_start(64'hFFC, 11'd2);
    expect_status("overflow", 1'b0, 1'b1, 1'b1, 1'b0);

    // Last word of memory
    do_start(64'hFFC, 11'd1);
    check("lastword_busy", 64'(busy_out), 64'd1);
    send_word(32'hDDCC_BBAA, 2);
    repeat (2) @(negedge clk);
    check("lastword_count", 64'(wa_q.size()), 64'd1);
    expect_write("lastword_w0", 0, 64'hFFC, 32'hDDCC_BBAA);
    expect_status("lastword_end", 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort after two bytes of the second word; simultaneous start must lose
    clear_log();
    do_start(64'h200, 11'd3);
    send_word(32'h0403_0201, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    abort_in = 1'b1;
    start_in = 1'b1;
    base_addr_in = 64'h0;
    len_words_in = 11'd1;
    @(negedge clk);
    abort_in = 1'b0;
    start_in = 1'b0;
    expect_status("abort", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_count", 64'(wa_q.size()), 64'd1);
    expect_write("abort_w0", 0, 64'h200, 32'h0403_0201);

    // Fresh load after abort must not see the discarded partial word
    clear_log();
    do_start(64'h0, 11'd1);
    send_word(32'h4433_2211, 0);
    repeat (2) @(negedge clk);
    expect_write("reload_w0", 0, 64'h0, 32'h4433_2211);
    expect_status("reload_end", 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RECV
    clear_log();
    do_start(64'h40, 11'd2);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #2;
    rst_n_in = 1'b0;
    #1;
    expect_status("midreset", 1'b0, 1'b0, 1'b1, 1'b0);
    check("midreset_ready", 64'(byte_ready_out), 64'd0);
    check("midreset_wr_addr", wr_addr_out, 64'd0);
    check("midreset_wr_data", 64'(wr_data_out), 64'd0);
    @(negedge clk);
    rst_n_in = 1'b1;
    @(negedge clk);

    // Restart; a start pulse during RECV is ignored
    clear_log();
    do_start(64'h40, 11'd2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_start(64'h2, 11'd1);
    check("start_ignored_busy", 64'(busy_out), 64'd1);
    check("start_ignored_error", 64'(error_out), 64'd0);
    send_byte(8'h33, 1);
    send_byte(8'h44, 0);
    send_word(32'h8877_6655, 3);
    repeat (2) @(negedge clk);
    check("restart_count", 64'(wa_q.size()), 64'd2);
    expect_write("restart_w0", 0, 64'h40, 32'h4433_2211);
    expect_write("restart_w1", 1, 64'h44, 32'h8877_6655);
    expect_status("restart_end", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
